// File: rtl/md_sequencer.sv
// md_sequencer: iterative multiply/divide sequencer owning the HI/LO registers
//   clk_i      system clock, rising edge
//   reset_ni   asynchronous active-low reset
//   start_i    one-cycle operation request, sampled in IDLE only
//   op_i       00 mult, 01 multu, 10 div, 11 divu
//   a_i, b_i   multiplicand/dividend and multiplier/divisor, sampled with start_i
//   hi_we_i    mthi write strobe (ignored while busy)
//   lo_we_i    mtlo write strobe (ignored while busy)
//   wdata_i    mthi/mtlo data
//   busy_o     operation in flight (PREP, CALC, FIX)
//   done_o     one-cycle pulse after HI/LO are updated
//   div_zero_o sticky: last div/divu had a zero divisor
//   hi_o, lo_o HI/LO registers
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;
    state_e state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, mag_a, mag_b, res_hi, res_lo;
    logic [2*WIDTH-1:0] acc_q, mult_next, div_next, neg_acc;
    logic [WIDTH:0] msum, drem, ddiff;
    logic [CW-1:0] cnt_q;
    logic [1:0] op_q;
    logic sign_q, sign_r_q, dz_q, is_div, sa, sb, b_zero;
    assign is_div = op_q[1];
    assign sa = ~op_q[0] & a_q[WIDTH-1];
    assign sb = ~op_q[0] & b_q[WIDTH-1];
    assign mag_a = sa ? -a_q : a_q;
    assign mag_b = sb ? -b_q : b_q;
    assign b_zero = b_q == '0;
    // acc_q holds {product high, multiplier} for multiply and {remainder, dividend/quotient} for divide;
    // b_q is reused as the magnitude of the multiplicand or divisor during CALC
    assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mult_next = {msum, acc_q[WIDTH-1:1]};
    assign drem = acc_q[2*WIDTH-1:WIDTH-1];
    assign ddiff = drem - {1'b0, b_q};
    assign div_next = ddiff[WIDTH] ? {drem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {ddiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign neg_acc = -acc_q;
    // sign_q/sign_r_q are zero for unsigned ops, so no extra op gating is needed here
    always_comb begin
        res_hi = dz_q ? a_q : !is_div ? (sign_q ? neg_acc[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH])
                                      : (sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH]);
        res_lo = dz_q ? '1 : !is_div ? (sign_q ? neg_acc[WIDTH-1:0] : acc_q[WIDTH-1:0])
                                     : (sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = start_i ? PREP : IDLE;
            PREP: state_d = (is_div && b_zero) ? FIX : CALC;
            CALC: state_d = (cnt_q == '0) ? FIX : CALC;
            FIX:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy_o = state_q == PREP || state_q == CALC || state_q == FIX;
        done_o = state_q == DONE;
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            sign_q <= 1'b0;
            sign_r_q <= 1'b0;
            dz_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                a_q <= a_i;
                b_q <= b_i;
                op_q <= op_i;
                dz_q <= 1'b0;
            end
            if (state_q == PREP) begin
                sign_q <= sa ^ sb;
                sign_r_q <= sa;
                b_q <= is_div ? mag_b : mag_a;
                acc_q <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
                cnt_q <= CW'(WIDTH - 1);
                if (is_div && b_zero) dz_q <= 1'b1;
            end
            if (state_q == CALC) begin
                acc_q <= is_div ? div_next : mult_next;
                cnt_q <= cnt_q - CW'(1);
            end
            if (state_q == FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (!busy_o) begin
                if (hi_we_i) hi_q <= wdata_i;
                if (lo_we_i) lo_q <= wdata_i;
            end
        end
    end
    assign div_zero_o = dz_q;
    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: table-driven plus directed-sequence check of md_sequencer
module tb_md_sequencer;
    logic clk_i = 1'b0, reset_ni = 1'b0, start_i = 1'b0, hi_we_i = 1'b0, lo_we_i = 1'b0;
    logic [1:0] op_i = '0;
    logic [31:0] a_i = '0, b_i = '0, wdata_i = '0;
    logic busy_o, done_o, div_zero_o;
    logic [31:0] hi_o, lo_o;
    int checks = 0, failures = 0;

    md_sequencer #(.WIDTH(32)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
        int          lat;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts an op at the next rising edge (E0) and checks latency, busy span, results.
    task automatic run_op(input string name, input vec_t v);
        int k, nbusy, ndone, lat;
        logic overlap;
        nbusy = 0; ndone = 0; lat = -1; overlap = 1'b0;
        @(negedge clk_i);
        op_i = v.op; a_i = v.a; b_i = v.b; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0; a_i = 32'hDEAD_BEEF; b_i = 32'h0BAD_F00D;
        for (k = 1; k <= 60 && ndone == 0; k++) begin
            @(negedge clk_i);
            if (busy_o && done_o) overlap = 1'b1;
            if (busy_o) nbusy++;
            if (done_o) begin ndone++; lat = k - 1; end
        end
        if (ndone == 0) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no done within 60 cycles", name);
        end else begin
            chk({name, "_latency"}, lat, v.lat);
            chk({name, "_busy_cycles"}, nbusy, v.lat);
            chk({name, "_hi"}, hi_o, v.hi);
            chk({name, "_lo"}, lo_o, v.lo);
            chk({name, "_div_zero"}, {31'b0, div_zero_o}, {31'b0, v.dz});
            chk({name, "_done_busy_overlap"}, {31'b0, overlap}, 32'd0);
        end
        @(negedge clk_i);
        chk({name, "_done_pulse_one_cycle"}, {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        int ndone;
        vec_t v;
        vecs[0] = '{2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 34};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
        vecs[6] = '{2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2};
        vecs[7] = '{2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};

        repeat (3) @(negedge clk_i);
        chk("reset_busy", {31'b0, busy_o}, 32'd0);
        chk("reset_done", {31'b0, done_o}, 32'd0);
        chk("reset_div_zero", {31'b0, div_zero_o}, 32'd0);
        chk("reset_hi", hi_o, 32'd0);
        chk("reset_lo", lo_o, 32'd0);
        reset_ni = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("div_zero_sticky", {31'b0, div_zero_o}, 32'd1);
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // mthi/mtlo together while idle
        @(negedge clk_i);
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h0000_0011;
        @(negedge clk_i);
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        chk("idle_write_hi", hi_o, 32'h11);
        chk("idle_write_lo", lo_o, 32'h11);

        // write alongside start takes effect; mid-CALC start and mthi are ignored
        @(negedge clk_i);
        op_i = 2'b01; a_i = 32'd6; b_i = 32'd9; start_i = 1'b1; hi_we_i = 1'b1; wdata_i = 32'h5555;
        @(negedge clk_i);
        start_i = 1'b0; hi_we_i = 1'b0;
        chk("start_write_hi", hi_o, 32'h5555);
        repeat (10) @(negedge clk_i);
        op_i = 2'b11; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1; hi_we_i = 1'b1; wdata_i = 32'hAA;
        @(negedge clk_i);
        start_i = 1'b0; hi_we_i = 1'b0;
        chk("busy_mthi_ignored", hi_o, 32'h5555);
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (done_o) ndone++;
        end
        chk("mid_start_done_count", ndone, 32'd1);
        chk("mid_start_hi", hi_o, 32'd0);
        chk("mid_start_lo", lo_o, 32'd54);

        // asynchronous reset in the middle of CALC
        @(negedge clk_i);
        op_i = 2'b01; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        #2 reset_ni = 1'b0;
        #1;
        chk("async_reset_busy", {31'b0, busy_o}, 32'd0);
        chk("async_reset_done", {31'b0, done_o}, 32'd0);
        chk("async_reset_hi", hi_o, 32'd0);
        chk("async_reset_lo", lo_o, 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        v = '{2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 34};
        run_op("post_reset_multu", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
